// File: rtl/capture_ctrl_mc.sv
// rtl/capture_ctrl_mc.sv - multi-channel ADC capture/trigger controller with circular RAM addressing
// Optional auto-trigger timeout is built when CAP_AUTO_TRIG_EN is defined.
module capture_ctrl_mc #(
    parameter int NUM_CH  = 3,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 9,
    parameter int AUTO_TO = 4096,
    parameter int TS_W    = $clog2(NUM_CH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     smpl_vld,
    input  logic [NUM_CH*DATA_W-1:0] smpl_data,
    input  logic                     run,
    input  logic                     stop,
    input  logic [TS_W-1:0]          trig_src,
    input  logic                     trig_ext,
    input  logic                     trig_edge,
    input  logic [DATA_W-1:0]        trig_lvl,
    input  logic [ADDR_W-1:0]        trig_pos,
    input  logic [3:0]               decimator,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [NUM_CH*DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0]        trig_addr,
    output logic                     busy,
    output logic                     cap_done,
    output logic                     trig_forced,
    input  logic                     dump_start,
    input  logic                     dump_adv,
    output logic                     dump_vld,
    output logic [ADDR_W-1:0]        dump_addr,
    output logic                     dump_last
);
    typedef enum logic [2:0] {S_IDLE, S_ARMING, S_ARMED, S_POST, S_DONE} state_t;
    state_t r_state, w_next;

    logic [TS_W-1:0]          r_src;
    logic                     r_edge;
    logic [DATA_W-1:0]        r_lvl;
    logic [ADDR_W-1:0]        r_pos;
    logic [3:0]               r_dec;
    logic [15:0]              r_dec_cnt;
    logic [ADDR_W-1:0]        r_ptr, r_fill, r_post, r_wr_addr, r_trig_addr, r_dump_addr;
    logic [NUM_CH*DATA_W-1:0] r_wr_data;
    logic [DATA_W-1:0]        r_prev;
    logic                     r_prev_vld, r_wr_en, r_dump_vld;

    logic                     w_run_ok, w_capt, w_wr, w_hit, w_force, w_trig, w_src_ok, w_dump_last;
    logic [DATA_W-1:0]        w_cur, w_lvl;
    logic [15:0]              w_dec_max;
    logic [ADDR_W-1:0]        w_pre_tgt;

    assign w_run_ok  = run && !stop && (r_state == S_IDLE || r_state == S_DONE);
    assign w_capt    = (r_state == S_ARMING) || (r_state == S_ARMED) || (r_state == S_POST);
    assign w_wr      = smpl_vld && (r_dec_cnt == 16'd0) && w_capt && !stop;
    assign w_dec_max = (16'd1 << r_dec) - 16'd1;
    // trig_pos is ADDR_W wide, so DEPTH-1-min(trig_pos,DEPTH-1) reduces to the bitwise inverse
    assign w_pre_tgt = ~r_pos;

    always_comb begin
        w_cur    = '0;
        w_lvl    = r_lvl;
        w_src_ok = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_src == TS_W'(c)) begin
                w_cur    = smpl_data[c*DATA_W +: DATA_W];
                w_src_ok = 1'b1;
            end
        end
        if (r_src == TS_W'(NUM_CH)) begin
            w_cur    = DATA_W'(trig_ext);
            w_lvl    = DATA_W'(1);
            w_src_ok = 1'b1;
        end
    end

    assign w_hit = w_src_ok && r_prev_vld &&
                   (r_edge ? (r_prev < w_lvl && w_cur >= w_lvl)
                           : (r_prev >= w_lvl && w_cur < w_lvl));
    assign w_trig = w_wr && (r_state == S_ARMED) && (w_hit || w_force);

`ifdef CAP_AUTO_TRIG_EN
    localparam int AUTO_W = $clog2(AUTO_TO + 1);
    logic [AUTO_W-1:0] r_auto;
    logic              r_forced;

    assign w_force = (r_auto == AUTO_W'(AUTO_TO - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || stop || w_run_ok) begin
            r_auto   <= '0;
            r_forced <= 1'b0;
        end else if (w_wr && r_state == S_ARMED) begin
            r_auto <= r_auto + AUTO_W'(1);
            if (w_force && !w_hit) r_forced <= 1'b1;
        end
    end
    assign trig_forced = r_forced;
`else
    assign w_force     = 1'b0;
    // AUTO_TO has no role without the timeout; this expression is constant 0
    assign trig_forced = (AUTO_TO < 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (stop) begin
            w_next = S_IDLE;
        end else if (w_run_ok) begin
            w_next = S_ARMING;
        end else begin
            case (r_state)
                S_ARMING: if (r_fill == w_pre_tgt ||
                              (w_wr && ({1'b0, r_fill} + (ADDR_W+1)'(1)) == {1'b0, w_pre_tgt}))
                              w_next = S_ARMED;
                S_ARMED:  if (w_trig) w_next = (r_pos == '0) ? S_DONE : S_POST;
                S_POST:   if (w_wr && r_post == ADDR_W'(1)) w_next = S_DONE;
                default:  w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_src       <= '0;
            r_edge      <= 1'b0;
            r_lvl       <= '0;
            r_pos       <= '0;
            r_dec       <= '0;
            r_dec_cnt   <= '0;
            r_ptr       <= '0;
            r_fill      <= '0;
            r_post      <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_wr_en     <= 1'b0;
            r_trig_addr <= '0;
            r_prev      <= '0;
            r_prev_vld  <= 1'b0;
            r_dump_vld  <= 1'b0;
            r_dump_addr <= '0;
        end else begin
            r_wr_en <= w_wr;
            if (w_run_ok)      r_dec_cnt <= '0;
            else if (smpl_vld) r_dec_cnt <= (r_dec_cnt >= w_dec_max) ? 16'd0 : r_dec_cnt + 16'd1;

            if (w_run_ok) begin
                r_src      <= trig_src;
                r_edge     <= trig_edge;
                r_lvl      <= trig_lvl;
                r_pos      <= trig_pos;
                r_dec      <= decimator;
                r_ptr      <= '0;
                r_fill     <= '0;
                r_prev_vld <= 1'b0;
            end else if (w_wr) begin
                r_wr_data  <= smpl_data;
                r_wr_addr  <= r_ptr;
                r_ptr      <= r_ptr + ADDR_W'(1);
                r_prev     <= w_cur;
                r_prev_vld <= 1'b1;
                if (r_state == S_ARMING) r_fill <= r_fill + ADDR_W'(1);
                if (w_trig) begin
                    r_trig_addr <= r_ptr;
                    r_post      <= r_pos;
                end else if (r_state == S_POST) begin
                    r_post <= r_post - ADDR_W'(1);
                end
            end

            // Readout walks oldest to newest; the newest is the last written address
            if (stop || w_run_ok) begin
                r_dump_vld <= 1'b0;
            end else if (r_state == S_DONE && dump_start) begin
                r_dump_vld  <= 1'b1;
                r_dump_addr <= r_wr_addr + ADDR_W'(1);
            end else if (r_dump_vld && dump_adv) begin
                if (w_dump_last) r_dump_vld  <= 1'b0;
                else             r_dump_addr <= r_dump_addr + ADDR_W'(1);
            end
        end
    end

    assign w_dump_last = r_dump_vld && (r_dump_addr == r_wr_addr);

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign trig_addr = r_trig_addr;
    assign busy      = w_capt;
    assign cap_done  = (r_state == S_DONE);
    assign dump_vld  = r_dump_vld;
    assign dump_addr = r_dump_addr;
    assign dump_last = w_dump_last;
endmodule

// File: doc/capture_ctrl_mc.md
Name: capture_ctrl_mc

Overview:
Parametrised multi-channel capture/trigger controller, the next generation of the scope's ADC capture engine. It takes decimated ADC samples from NUM_CH channels and writes them into a circular sample RAM of depth 2^ADDR_W. It detects a programmable level/edge trigger on any channel or the external trigger, and holds a programmable pre/post-trigger split. After capture it generates oldest-to-newest dump addressing for the command/dump logic.

Parameters:
NUM_CH, 3, number of ADC channels (1..8)
DATA_W, 8, bits per channel sample
ADDR_W, 9, RAM address width; DEPTH = 2^ADDR_W
AUTO_TO, 4096, auto-trigger timeout in accepted samples (used only with CAP_AUTO_TRIG_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
smpl_vld  in  1  one-clk strobe, new ADC sample set present
smpl_data  in  NUM_CH*DATA_W  channel samples, ch0 in LSBs
run  in  1  pulse: start capture
stop  in  1  pulse: abort to IDLE
trig_src  in  TS_W=$clog2(NUM_CH+1)  0..NUM_CH-1 = channel, NUM_CH = trig_ext, larger = no trigger
trig_ext  in  1  external trigger level (already synchronised)
trig_edge  in  1  1 = rising, 0 = falling
trig_lvl  in  DATA_W  trigger threshold (unsigned)
trig_pos  in  ADDR_W  samples written after the trigger sample
decimator  in  4  keep 1 of every 2^decimator strobes
wr_en  out  1  RAM write strobe
wr_addr  out  ADDR_W  RAM write address
wr_data  out  NUM_CH*DATA_W  registered sample set
trig_addr  out  ADDR_W  address of trigger sample
busy  out  1  high in ARMING/ARMED/POST
cap_done  out  1  capture complete
trig_forced  out  1  capture ended by auto-trigger
dump_start  in  1  pulse: begin readout
dump_adv  in  1  advance readout by one address
dump_vld  out  1  dump_addr valid
dump_addr  out  ADDR_W  readout address
dump_last  out  1  dump_addr is the newest sample

Behaviour:
- Reset (rst_n=0 at posedge clk): state IDLE. All outputs 0. All counters and pointers 0.
- Decimation: 16-bit dec_cnt increments on each smpl_vld and wraps at 2^decimator-1. A sample is accepted when smpl_vld=1 and dec_cnt==0. dec_cnt clears on run.
- Writes: in ARMING/ARMED/POST, each accepted sample gives wr_en=1 exactly one clk later. wr_data is registered from smpl_data and wr_addr holds the current pointer. The pointer increments after each write and wraps DEPTH-1 -> 0.
- Trigger detect (on accepted samples in ARMED only): prev holds the selected source's previous accepted value.
  - Rising edge: prev < trig_lvl and cur >= trig_lvl.
  - Falling edge: prev >= trig_lvl and cur < trig_lvl.
  - For the external source, the channel value is replaced by trig_ext, with lvl=1.
  - prev_vld clears on run and sets after the first accepted sample; no trigger fires while prev_vld=0.
- State machine:
  - IDLE: run -> ARMING. Clears cap_done, trig_forced, fill_cnt and the pointer.
  - ARMING: counts writes in fill_cnt. When fill_cnt == pre_tgt = DEPTH-1-min(trig_pos,DEPTH-1) -> ARMED. If pre_tgt = 0, go straight to ARMED on the next clk.
  - ARMED: keeps writing. The trigger sample is written, trig_addr latches its address, post_cnt loads trig_pos. If trig_pos=0 -> DONE after the trigger write, else -> POST.
  - POST: post_cnt decrements per write. After the write at post_cnt==1 -> DONE.
  - DONE: cap_done=1, no writes. run restarts as from IDLE. dump_start is accepted only here.
- Dump:
  - dump_start sets dump_vld=1 and dump_addr = last_wr+1 (mod DEPTH, the oldest sample).
  - Each dump_adv while dump_vld increments dump_addr with wrap.
  - dump_last=1 when dump_addr == last_wr. dump_adv while dump_last clears dump_vld.
  - dump_start while dump_vld restarts the dump from the oldest sample.
- Priority: stop > run > everything else.
  - stop in any state -> IDLE, clears busy, cap_done, dump_vld and trig_forced; a pending write is discarded.
  - run in ARMING/ARMED/POST is ignored.
- trig_src, trig_edge, trig_lvl, trig_pos and decimator are sampled into internal registers on the accepted run. Changes mid-capture have no effect.
- An accepted sample arriving on the same clk as a state transition is processed under the state the sample was accepted in.

Optional Feature:
CAP_AUTO_TRIG_EN
- Defined: in ARMED, a counter of accepted samples reaching AUTO_TO forces a trigger on that sample, and trig_forced=1 until the next run/stop.
- Undefined: no counter is built, trig_forced is tied 0, and ARMED waits indefinitely.

Test Plan:
- Defaults, trig_pos=100, rising, lvl=0x80, trig_src=1, decimator=0; ch1 ramps 0x00->0xFF, one step per smpl_vld.
  -> 411 writes before ARMED; trigger on ch1=0x80; exactly 100 more writes; cap_done=1.
  -> Dump gives 512 addresses starting at trig_addr+101 mod 512; dump_last at trig_addr+100.
- decimator=3, 64 smpl_vld strobes in ARMING -> exactly 8 wr_en pulses, each 1 clk after the 1st, 9th, 17th... strobe.
- trig_src=2, falling, lvl=0x40; ch2 crosses 0x40 downward during ARMING, then again during ARMED -> only the ARMED crossing triggers.
- stop asserted at post_cnt=50 -> IDLE next clk; busy=0, cap_done=0, no further wr_en. run together with stop -> stays IDLE.
- trig_pos=511 (pre_tgt=0), trig_src=3 (ext), rising; trig_ext held 1 from run -> no trigger on first sample (prev_vld=0). trig_ext 0->1 later -> trigger, 511 post writes with pointer wrap.
- With CAP_AUTO_TRIG_EN, AUTO_TO=16, no crossings -> forced trigger on the 16th ARMED sample, trig_forced=1. Without the macro -> remains ARMED after 10000 samples.
